// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between the Avalon host path
// (requester 0) and the calculation engine (requester 1). It grants round-robin,
// limits each owner to MAX_BURST accesses while the other requester waits,
// lets an owner hold the port with lock, rejects out-of-range addresses and
// returns read data one cycle after the access.
// Optional feature macro: ARB_STATS_EN adds per-requester access counters and
// a range-error counter.
module sram_port_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8,
    parameter int MAXADDR   = 4128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        lock,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_STATS_EN
    output logic [15:0]       stat_acc0,
    output logic [15:0]       stat_acc1,
    output logic [7:0]        stat_err,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    state_e             state_q, state_d;
    logic               lastOwner_q, lastOwner_d;
    logic [CNT_W-1:0]   burstCnt_q, burstCnt_d;
    logic [CNT_W-1:0]   cntInc;
    logic [1:0]         rvalid_q, rvalid_d;
    logic [1:0]         err_q, err_d;

    logic               owner;
    logic               ownReq;
    logic               otherReq;
    logic               access;
    logic               addrOk;
    logic               curWe;
    logic [ADDR_W-1:0]  curAddr;
    logic [DATA_W-1:0]  curWdata;

    // Select the current owner's request fields and decide whether an access is taken this cycle
    always_comb begin
        owner    = (state_q == OWN1);
        ownReq   = owner ? req[1]  : req[0];
        otherReq = owner ? req[0]  : req[1];
        curWe    = owner ? we[1]   : we[0];
        curAddr  = owner ? addr1   : addr0;
        curWdata = owner ? wdata1  : wdata0;
        access   = (state_q != IDLE) && ownReq;
        addrOk   = (curAddr <= ADDR_W'(MAXADDR));
        cntInc   = (burstCnt_q == CNT_W'(MAX_BURST)) ? burstCnt_q : burstCnt_q + CNT_W'(1);
    end

    // State register with burst counter and round-robin memory of the last owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lastOwner_q <= 1'b1;
            burstCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lastOwner_q <= lastOwner_d;
            burstCnt_q  <= burstCnt_d;
        end
    end

    // Next-state: arbitration from IDLE, burst limit handover and release when the owner drops req
    always_comb begin
        state_d     = state_q;
        lastOwner_d = lastOwner_q;
        burstCnt_d  = burstCnt_q;
        case (state_q)
            IDLE: begin
                burstCnt_d = '0;
                if (req == 2'b11)
                    state_d = lastOwner_q ? OWN0 : OWN1;
                else if (req[0])
                    state_d = OWN0;
                else if (req[1])
                    state_d = OWN1;
            end
            OWN0, OWN1: begin
                if (ownReq) begin
                    burstCnt_d = cntInc;
                    if ((cntInc == CNT_W'(MAX_BURST)) && !lock[owner] && otherReq) begin
                        state_d     = owner ? OWN0 : OWN1;
                        burstCnt_d  = '0;
                        lastOwner_d = owner;
                    end
                end else begin
                    state_d     = otherReq ? (owner ? OWN0 : OWN1) : IDLE;
                    burstCnt_d  = '0;
                    lastOwner_d = owner;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: grant decode, SRAM drive from the owner, and next-cycle read/error responses
    always_comb begin
        gnt       = {state_q == OWN1, state_q == OWN0};
        mem_en    = access && addrOk;
        mem_we    = mem_en && curWe;
        mem_addr  = mem_en ? curAddr : '0;
        mem_wdata = mem_we ? curWdata : '0;
        rvalid_d  = '0;
        err_d     = '0;
        if (mem_en && !curWe)
            rvalid_d[owner] = 1'b1;
        if (access && !addrOk)
            err_d[owner] = 1'b1;
    end

    // Response registers; these survive a grant change so the old owner still gets its answer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            err_q    <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign rvalid = rvalid_q;
    assign err    = err_q;
    // mem_rdata comes straight from the macro's output register, gated so rdata is zero when not valid
    assign rdata  = (|rvalid_q) ? mem_rdata : '0;

`ifdef ARB_STATS_EN
    logic [15:0] statAcc0_q, statAcc1_q;
    logic [7:0]  statErr_q;

    // Saturating usage counters: completed SRAM accesses per requester and total range errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            statAcc0_q <= '0;
            statAcc1_q <= '0;
            statErr_q  <= '0;
        end else begin
            if (mem_en && !owner && (statAcc0_q != 16'hFFFF))
                statAcc0_q <= statAcc0_q + 16'd1;
            if (mem_en && owner && (statAcc1_q != 16'hFFFF))
                statAcc1_q <= statAcc1_q + 16'd1;
            if ((|err_d) && (statErr_q != 8'hFF))
                statErr_q <= statErr_q + 8'd1;
        end
    end

    assign stat_acc0 = statAcc0_q;
    assign stat_acc1 = statAcc1_q;
    assign stat_err  = statErr_q;
`endif

endmodule
